// File: rtl/rgb2raw_pkg.sv
// Shared types and constants for the Bayer mosaic encoder.
// Pattern codes and FSM state encodings.
package rgb2raw_pkg;

  localparam logic [1:0] PAT_RGGB = 2'd0;
  localparam logic [1:0] PAT_GRBG = 2'd1;
  localparam logic [1:0] PAT_GBRG = 2'd2;
  localparam logic [1:0] PAT_BGGR = 2'd3;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    VBLANK    = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

endpackage

// File: rtl/rgb2raw_if.sv
// VGA-timed stream bundle: RGB in, raw Bayer out.
// master drives the RGB side, slave is the encoder.
interface rgb2raw_if #(
  parameter int DW = 8
) ();

  logic          i_vga_vsync;
  logic          i_vga_hsync;
  logic          i_vga_de;
  logic [DW-1:0] i_vga_r;
  logic [DW-1:0] i_vga_g;
  logic [DW-1:0] i_vga_b;
  logic          o_vga_vsync;
  logic          o_vga_hsync;
  logic          o_vga_de;
  logic [DW-1:0] raw_data;

  modport master (
    output i_vga_vsync, i_vga_hsync, i_vga_de,
    output i_vga_r, i_vga_g, i_vga_b,
    input  o_vga_vsync, o_vga_hsync, o_vga_de,
    input  raw_data
  );

  modport slave (
    input  i_vga_vsync, i_vga_hsync, i_vga_de,
    input  i_vga_r, i_vga_g, i_vga_b,
    output o_vga_vsync, o_vga_hsync, o_vga_de,
    output raw_data
  );

endinterface

// File: rtl/rgb2raw_line_chk.sv
// Row/column counters, frame-start detect and
// per-frame line-length consistency check.
module raw_line_chk #(
  parameter int CNT_W = 16
) (
  input  logic             sclk,
  input  logic             s_rst,
  input  logic             vsync,
  input  logic             de,
  input  logic             active,
  output logic             frame_start,
  output logic             row_par,
  output logic             col_par,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] frame_lines,
  output logic             line_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             vs_q;
  logic             de_q;
  logic             de_fall;
  logic             first_done;
  logic [CNT_W-1:0] row_cnt;
  logic [CNT_W-1:0] col_cnt;
  logic [CNT_W-1:0] ref_len;

  assign frame_start = vsync & ~vs_q;
  assign de_fall     = ~de & de_q;
  assign row_par     = row_cnt[0];
  assign col_par     = col_cnt[0];

  // previous vsync/de for edge detection
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      vs_q <= 1'b0;
      de_q <= 1'b0;
    end else begin
      vs_q <= vsync;
      de_q <= de;
    end
  end

  // pixel column, saturating, cleared outside de
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      col_cnt <= '0;
    end else if (!de) begin
      col_cnt <= '0;
    end else if (col_cnt != CNT_MAX) begin
      col_cnt <= col_cnt + 1'b1;
    end
  end

  // line index, saturating, held at 0 during vsync
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      row_cnt <= '0;
    end else if (vsync) begin
      row_cnt <= '0;
    end else if (de_fall && row_cnt != CNT_MAX) begin
      row_cnt <= row_cnt + 1'b1;
    end
  end

  // frame stats; frame start wins over a same-cycle line end
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      ref_len     <= '0;
      first_done  <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      line_err    <= 1'b0;
    end else if (frame_start) begin
      if (active) begin
        frame_lines <= row_cnt;
        line_len    <= ref_len;
      end
      line_err   <= 1'b0;
      first_done <= 1'b0;
    end else if (de_fall) begin
      if (!first_done) begin
        ref_len    <= col_cnt;
        first_done <= 1'b1;
      end else if (col_cnt != ref_len) begin
        line_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb2raw.sv
// Bayer mosaic encoder: RGB VGA stream to 8-bit raw,
// one-cycle latency, partial frames after reset suppressed.
module rgb2raw
  import rgb2raw_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             sclk,
  input  logic             s_rst,
  rgb2raw_if.slave         vga,
  input  logic [1:0]       cfg_pattern,
  output logic [CNT_W-1:0] o_line_len,
  output logic [CNT_W-1:0] o_frame_lines,
  output logic             o_line_err
);

  state_t        state;
  state_t        state_nx;
  logic [1:0]    pat_q;
  logic [1:0]    pat_use;
  logic          frame_start;
  logic          row_par;
  logic          col_par;
  logic          py;
  logic          px;
  logic          emit;
  logic [DW-1:0] pix;

  raw_line_chk #(
    .CNT_W (CNT_W)
  ) u_chk (
    .sclk        (sclk),
    .s_rst       (s_rst),
    .vsync       (vga.i_vga_vsync),
    .de          (vga.i_vga_de),
    .active      (state == ACTIVE),
    .frame_start (frame_start),
    .row_par     (row_par),
    .col_par     (col_par),
    .line_len    (o_line_len),
    .frame_lines (o_frame_lines),
    .line_err    (o_line_err)
  );

  // state register
  always_ff @(posedge sclk) begin
    if (s_rst) state <= WAIT_SYNC;
    else       state <= state_nx;
  end

  // frame tracking: only emit once a full frame has begun
  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT_SYNC: if (vga.i_vga_vsync)  state_nx = VBLANK;
      VBLANK:    if (!vga.i_vga_vsync) state_nx = ACTIVE;
      ACTIVE:    if (vga.i_vga_vsync)  state_nx = VBLANK;
      default:   state_nx = WAIT_SYNC;
    endcase
  end

  // pattern is frozen for the whole frame
  always_ff @(posedge sclk) begin
    if (s_rst)            pat_q <= 2'd0;
    else if (frame_start) pat_q <= cfg_pattern;
  end

  assign pat_use = frame_start ? cfg_pattern : pat_q;
  assign py      = (row_par & ~vga.i_vga_vsync) ^ pat_use[1];
  assign px      = col_par ^ pat_use[0];
  assign emit    = vga.i_vga_de && (state != WAIT_SYNC);

  // colour select by Bayer phase
  always_comb begin
    pix = vga.i_vga_g;
    unique case (1'b1)
      (!py && !px): pix = vga.i_vga_r;
      (py && px):   pix = vga.i_vga_b;
      default:      pix = vga.i_vga_g;
    endcase
  end

  // one-cycle output pipeline
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      vga.o_vga_vsync <= 1'b0;
      vga.o_vga_hsync <= 1'b0;
      vga.o_vga_de    <= 1'b0;
      vga.raw_data    <= '0;
    end else begin
      vga.o_vga_vsync <= vga.i_vga_vsync;
      vga.o_vga_hsync <= vga.i_vga_hsync;
      vga.o_vga_de    <= emit;
      vga.raw_data    <= emit ? pix : '0;
    end
  end

endmodule

// File: tb/tb_rgb2raw.sv
// Scoreboard bench for rgb2raw: directed frames,
// a second narrow-counter instance exercises saturation.
module tb_rgb2raw;
  import rgb2raw_pkg::*;

  localparam logic [7:0] CR = 8'h11;
  localparam logic [7:0] CG = 8'h22;
  localparam logic [7:0] CB = 8'h33;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  logic        sclk = 1'b0;
  logic        s_rst;
  logic [1:0]  cfg_pattern;
  logic [15:0] line_len;
  logic [15:0] frame_lines;
  logic        line_err;
  logic [3:0]  line_len_s;
  logic [3:0]  frame_lines_s;
  logic        line_err_s;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t q[$];
  exp_t qs[$];
  logic vs_d;
  logic hs_d;
  logic rst_d;

  rgb2raw_if #(.DW(8)) vga ();
  rgb2raw_if #(.DW(8)) vga_s ();

  assign vga_s.i_vga_vsync = vga.i_vga_vsync;
  assign vga_s.i_vga_hsync = vga.i_vga_hsync;
  assign vga_s.i_vga_de    = vga.i_vga_de;
  assign vga_s.i_vga_r     = vga.i_vga_r;
  assign vga_s.i_vga_g     = vga.i_vga_g;
  assign vga_s.i_vga_b     = vga.i_vga_b;

  rgb2raw #(.DW(8), .CNT_W(16)) dut (
    .sclk          (sclk),
    .s_rst         (s_rst),
    .vga           (vga),
    .cfg_pattern   (cfg_pattern),
    .o_line_len    (line_len),
    .o_frame_lines (frame_lines),
    .o_line_err    (line_err)
  );

  rgb2raw #(.DW(8), .CNT_W(4)) dut_s (
    .sclk          (sclk),
    .s_rst         (s_rst),
    .vga           (vga_s),
    .cfg_pattern   (cfg_pattern),
    .o_line_len    (line_len_s),
    .o_frame_lines (frame_lines_s),
    .o_line_err    (line_err_s)
  );

  always #5 sclk = ~sclk;

  always @(posedge sclk) begin
    cyc   <= cyc + 1;
    vs_d  <= vga.i_vga_vsync;
    hs_d  <= vga.i_vga_hsync;
    rst_d <= s_rst;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] pat,
                                       input int row, input int col);
    logic py;
    logic px;
    py = row[0] ^ pat[1];
    px = col[0] ^ pat[0];
    if (!py && !px) return CR;
    if (py && px)   return CB;
    return CG;
  endfunction

  // main instance monitor
  always @(negedge sclk) begin
    exp_t e;
    chk("vsync_out", {31'd0, vga.o_vga_vsync}, {31'd0, vs_d & ~rst_d});
    chk("hsync_out", {31'd0, vga.o_vga_hsync}, {31'd0, hs_d & ~rst_d});
    if (vga.o_vga_de === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pixel actual=%0h required=none",
                 vga.raw_data);
      end else begin
        e = q.pop_front();
        chk("raw_data", {24'd0, vga.raw_data}, {24'd0, e.d});
        chk("latency", cyc, e.c + 1);
      end
    end else begin
      chk("raw_idle", {24'd0, vga.raw_data}, 32'd0);
    end
  end

  // saturating instance monitor
  always @(negedge sclk) begin
    exp_t e;
    if (vga_s.o_vga_de === 1'b1) begin
      if (qs.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pixel_s actual=%0h required=none",
                 vga_s.raw_data);
      end else begin
        e = qs.pop_front();
        chk("raw_data_s", {24'd0, vga_s.raw_data}, {24'd0, e.d});
      end
    end else begin
      chk("raw_idle_s", {24'd0, vga_s.raw_data}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic pixel(input int row, input int col,
                       input logic [1:0] pat, input bit emit);
    vga.i_vga_de = 1'b1;
    if (emit) begin
      q.push_back('{model(pat, row, (col > 65535) ? 65535 : col), cyc});
      qs.push_back('{model(pat, row, (col > 15) ? 15 : col), cyc});
    end
    tick();
  endtask

  task automatic line_end();
    vga.i_vga_de    = 1'b0;
    vga.i_vga_hsync = 1'b1;
    tick();
    vga.i_vga_hsync = 1'b0;
    tick();
  endtask

  task automatic line(input int len, input int row,
                      input logic [1:0] pat, input bit emit);
    for (int c = 0; c < len; c++) pixel(row, c, pat, emit);
    line_end();
  endtask

  task automatic vs_pulse();
    vga.i_vga_de    = 1'b0;
    vga.i_vga_vsync = 1'b1;
    repeat (2) tick();
    vga.i_vga_vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic chk_stats(input string nm, input int lines,
                           input int len, input bit err);
    chk({nm, "_frame_lines"}, {16'd0, frame_lines}, lines);
    chk({nm, "_line_len"}, {16'd0, line_len}, len);
    chk({nm, "_line_err"}, {31'd0, line_err}, {31'd0, err});
  endtask

  initial begin
    s_rst           = 1'b1;
    cfg_pattern     = PAT_RGGB;
    vga.i_vga_vsync = 1'b0;
    vga.i_vga_hsync = 1'b0;
    vga.i_vga_de    = 1'b0;
    vga.i_vga_r     = CR;
    vga.i_vga_g     = CG;
    vga.i_vga_b     = CB;
    repeat (3) tick();
    chk("rst_de", {31'd0, vga.o_vga_de}, 32'd0);
    chk("rst_raw", {24'd0, vga.raw_data}, 32'd0);
    chk_stats("rst", 0, 0, 1'b0);
    s_rst = 1'b0;

    // mid-frame start: nothing emitted before first vsync
    line(4, 0, PAT_RGGB, 1'b0);
    line(4, 1, PAT_RGGB, 1'b0);
    vs_pulse();
    chk_stats("first_vs", 0, 0, 1'b0);

    // 4x2 RGGB
    line(4, 0, PAT_RGGB, 1'b1);
    line(4, 1, PAT_RGGB, 1'b1);
    cfg_pattern = PAT_BGGR;
    vs_pulse();
    chk_stats("frame_a", 2, 4, 1'b0);

    // 4x2 BGGR, pattern change mid-frame is ignored
    line(4, 0, PAT_BGGR, 1'b1);
    cfg_pattern = PAT_GRBG;
    line(4, 1, PAT_BGGR, 1'b1);
    vs_pulse();
    chk_stats("frame_b", 2, 4, 1'b0);

    // GRBG, lengths 8,8,7
    line(8, 0, PAT_GRBG, 1'b1);
    line(8, 1, PAT_GRBG, 1'b1);
    chk("err_equal", {31'd0, line_err}, 32'd0);
    for (int c = 0; c < 7; c++) pixel(2, c, PAT_GRBG, 1'b1);
    vga.i_vga_de = 1'b0;
    tick();
    chk("err_short", {31'd0, line_err}, 32'd1);
    line_end();
    vs_pulse();
    chk_stats("frame_c", 3, 8, 1'b0);

    // reset during line 2
    line(4, 0, PAT_GRBG, 1'b1);
    pixel(1, 0, PAT_GRBG, 1'b1);
    pixel(1, 1, PAT_GRBG, 1'b1);
    s_rst        = 1'b1;
    vga.i_vga_de = 1'b1;
    tick();
    chk("mid_rst_de", {31'd0, vga.o_vga_de}, 32'd0);
    chk("mid_rst_raw", {24'd0, vga.raw_data}, 32'd0);
    chk_stats("mid_rst", 0, 0, 1'b0);
    s_rst = 1'b0;
    pixel(1, 2, PAT_GRBG, 1'b0);
    pixel(1, 3, PAT_GRBG, 1'b0);
    line_end();
    line(4, 2, PAT_GRBG, 1'b0);
    cfg_pattern = PAT_GBRG;
    vs_pulse();
    chk_stats("post_rst_vs", 0, 0, 1'b0);

    // full frame after reset, GBRG 5x3
    for (int r = 0; r < 3; r++) line(5, r, PAT_GBRG, 1'b1);
    cfg_pattern = PAT_RGGB;
    vs_pulse();
    chk_stats("frame_e", 3, 5, 1'b0);

    // long line: narrow counter saturates, no wrap
    line(18, 0, PAT_RGGB, 1'b1);
    vs_pulse();
    chk_stats("frame_f", 1, 18, 1'b0);
    chk("sat_line_len", {28'd0, line_len_s}, 32'd15);
    chk("sat_frame_lines", {28'd0, frame_lines_s}, 32'd1);
    chk("sat_line_err", {31'd0, line_err_s}, 32'd0);

    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    chk("queue_drained_s", qs.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
